// File: rtl/fetch_unit.sv
// Instruction-fetch front end: req/ack fetch to imem, DEPTH-entry prefetch FIFO, decode redirects.
// Optional FETCH_PERF_EN adds saturating bubble/discard counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        InstrValidF,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubble,
    output logic [31:0] perf_discard
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_t             state, state_n;
    logic [31:0]        fetch_pc, fetch_pc_n;
    logic [31:0]        disc_addr, disc_addr_n;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, cnt_after_pop;
    entry_t             mem [DEPTH];
    logic               pop, push, flush, drop;
    logic [31:0]        target;

    assign target        = redirect_pc & 32'hFFFF_FFFC;
    assign InstrValidF   = (count != '0);
    assign pop           = InstrValidF & ~StallD;
    assign cnt_after_pop = count - CNT_W'(pop);
    assign InstrF        = InstrValidF ? mem[rd_ptr].instr : 32'h0;
    assign PCF           = InstrValidF ? mem[rd_ptr].pc : fetch_pc;
    assign PCPlus4F      = PCF + 32'd4;

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        disc_addr_n = disc_addr;
        push        = 1'b0;
        flush       = 1'b0;
        drop        = 1'b0;
        imem_req    = 1'b0;
        imem_addr   = fetch_pc;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_n = target;
                end else if (cnt_after_pop < DEPTH_C) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_n = target;
                    if (imem_ack) begin
                        drop    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        disc_addr_n = fetch_pc;
                        state_n     = DISCARD;
                    end
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc + 32'd4;
                    if (cnt_after_pop + CNT_W'(1) >= DEPTH_C) state_n = IDLE;
                end
            end
            DISCARD: begin
                // Old address stays on the bus until memory answers it
                imem_req  = 1'b1;
                imem_addr = disc_addr;
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_n = target;
                end
                if (imem_ack) begin
                    drop    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            disc_addr <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            disc_addr <= disc_addr_n;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{instr: imem_rdata, pc: fetch_pc};
    end

`ifdef FETCH_PERF_EN
    logic [32:0] bubble_sum, discard_sum;
    assign bubble_sum  = {1'b0, perf_bubble} + 33'(~InstrValidF & ~StallD);
    assign discard_sum = {1'b0, perf_discard} + (flush ? 33'(count) : 33'd0) + 33'(drop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_bubble  <= '0;
            perf_discard <= '0;
        end else begin
            perf_bubble  <= bubble_sum[32]  ? 32'hFFFF_FFFF : bubble_sum[31:0];
            perf_discard <= discard_sum[32] ? 32'hFFFF_FFFF : discard_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/full, redirects, PC wrap, mid-request reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        StallD;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        InstrValidF;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        ack_auto, ack_man;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble, perf_discard, disc_snap;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .StallD(StallD), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .InstrValidF(InstrValidF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
`ifdef FETCH_PERF_EN
        , .perf_bubble(perf_bubble), .perf_discard(perf_discard)
`endif
    );

    always #5 clk = ~clk;

    // Memory returns a word derived from its address so stale data is recognisable
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_rdata = instr_of(imem_addr);
    assign imem_ack   = ack_auto ? imem_req : ack_man;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; StallD = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        ack_auto = 1'b0; ack_man = 1'b0;
        cyc(); cyc();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(InstrValidF), 32'd0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_pc", PCF, 32'h0);
        chk("rst_pc4", PCPlus4F, 32'h4);

        // streaming with an ack every cycle
        reset = 1'b1; ack_auto = 1'b1;
        cyc(); chk("t1_addr0", imem_addr, 32'h0); chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_v0", 32'(InstrValidF), 32'd0);
        cyc(); chk("t1_addr4", imem_addr, 32'h4); chk("t1_i0", InstrF, instr_of(32'h0));
        chk("t1_v1", 32'(InstrValidF), 32'd1); chk("t1_pc0", PCF, 32'h0);
        cyc(); chk("t1_addr8", imem_addr, 32'h8); chk("t1_i4", InstrF, instr_of(32'h4));
        cyc(); chk("t1_addrC", imem_addr, 32'hC); chk("t1_pc8", PCF, 32'h8);
        chk("t1_pc4_8", PCPlus4F, 32'hC);

        // decode stall fills the buffer and stops requests
        StallD = 1'b1;
        cyc(); chk("t2_full_req", 32'(imem_req), 32'd0);
        repeat (4) cyc();
        chk("t2_hold_req", 32'(imem_req), 32'd0); chk("t2_hold_pc", PCF, 32'h8);
        chk("t2_hold_i", InstrF, instr_of(32'h8));
        StallD = 1'b0;
        cyc(); chk("t2_pcC", PCF, 32'hC); chk("t2_addr10", imem_addr, 32'h10);
        chk("t2_req", 32'(imem_req), 32'd1);
        cyc(); chk("t2_pc10", PCF, 32'h10);
        cyc(); chk("t2_pc14", PCF, 32'h14);

        // redirect while a request to 8 is pending, ack arrives 3 cycles later
        ack_auto = 1'b0; ack_man = 1'b0;
        do_reset(); ack_auto = 1'b1;
        cyc(); cyc(); cyc();
        chk("t3_addr8", imem_addr, 32'h8);
        ack_auto = 1'b0;
        cyc(); chk("t3_pend", imem_addr, 32'h8); chk("t3_empty", 32'(InstrValidF), 32'd0);
`ifdef FETCH_PERF_EN
        disc_snap = perf_discard;
`endif
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cyc(); chk("t3_old_addr", imem_addr, 32'h8); chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_pcf", PCF, 32'h100);
        redirect_valid = 1'b0;
        cyc(); chk("t3_hold1", imem_addr, 32'h8);
        cyc(); chk("t3_hold2", imem_addr, 32'h8); ack_man = 1'b1;
        cyc(); chk("t3_idle", 32'(imem_req), 32'd0); chk("t3_drop", 32'(InstrValidF), 32'd0);
        ack_man = 1'b0;
`ifdef FETCH_PERF_EN
        chk("t3_perf_disc", perf_discard, disc_snap + 32'd1);
`endif
        cyc(); chk("t3_addr100", imem_addr, 32'h100); chk("t3_req2", 32'(imem_req), 32'd1);
        ack_man = 1'b1;
        cyc(); chk("t3_pc100", PCF, 32'h100); chk("t3_i100", InstrF, instr_of(32'h100));

        // redirect together with ack and pop
        chk("t4_addr104", imem_addr, 32'h104);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cyc(); chk("t4_empty", 32'(InstrValidF), 32'd0); chk("t4_pcf", PCF, 32'h200);
        chk("t4_noreq", 32'(imem_req), 32'd0);
        redirect_valid = 1'b0; ack_man = 1'b0;
        cyc(); chk("t4_addr200", imem_addr, 32'h200); ack_man = 1'b1;
        cyc(); chk("t4_pc200", PCF, 32'h200); chk("t4_i200", InstrF, instr_of(32'h200));

        // wrap at the top of the address space
        ack_man = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc(); chk("t5_disc_addr", imem_addr, 32'h204);
        redirect_valid = 1'b0; ack_man = 1'b1;
        cyc(); chk("t5_idle", 32'(imem_req), 32'd0); ack_man = 1'b0;
        cyc(); chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC); ack_man = 1'b1;
        cyc(); ack_man = 1'b0;
        chk("t5_pcf", PCF, 32'hFFFF_FFFC); chk("t5_pc4", PCPlus4F, 32'h0);
        chk("t5_instr", InstrF, instr_of(32'hFFFF_FFFC)); chk("t5_addr0", imem_addr, 32'h0);

        // reset in the middle of a pending request, stray ack afterwards
        chk("t6_pend", 32'(imem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_req", 32'(imem_req), 32'd0); chk("t6_pcf", PCF, 32'h0);
        chk("t6_valid", 32'(InstrValidF), 32'd0);
        cyc();
        reset = 1'b1; ack_man = 1'b1;
        cyc(); ack_man = 1'b0;
        chk("t6_stray", 32'(InstrValidF), 32'd0); chk("t6_addr", imem_addr, 32'h0);
        chk("t6_req2", 32'(imem_req), 32'd1);
        cyc(); chk("t6_stray2", 32'(InstrValidF), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
